// File: rtl/lsu_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The slave modport is the LSU; the master side is the core plus the memory.
interface lsu_if;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    modport slave (
        input  mem_write, mem_read, funct3, addr, wdata, dm_rd,
        output rdata, stall, misalign, dm_we, dm_addr, dm_wd
    );

    modport master (
        output mem_write, mem_read, funct3, addr, wdata, dm_rd,
        input  rdata, stall, misalign, dm_we, dm_addr, dm_wd
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: word-addressed memory, load lane extraction with
// extension, and a two-cycle read-modify-write for byte/halfword stores.
module lsu (
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    state_t      st_q, st_d;
    logic [31:0] a_q, a_d;
    logic [31:0] d_q, d_d;
    logic [2:0]  f_q, f_d;
    logic [31:0] old_q, old_d;

    logic        req;
    logic        illegal;
    logic [31:0] merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign req = bus.mem_write | bus.mem_read;

    // Stores have no unsigned variants, so BU/HU are illegal when writing.
    always_comb begin
        illegal = 1'b0;
        case (bus.funct3)
            F_B:  illegal = 1'b0;
            F_H:  illegal = bus.addr[0];
            F_W:  illegal = (bus.addr[1:0] != 2'b00);
            F_BU: illegal = bus.mem_write;
            F_HU: illegal = bus.mem_write | bus.addr[0];
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (f_q == F_H) begin
            if (a_q[1]) merged[31:16] = d_q[15:0];
            else        merged[15:0]  = d_q[15:0];
        end else begin
            case (a_q[1:0])
                2'd0: merged[7:0]   = d_q[7:0];
                2'd1: merged[15:8]  = d_q[7:0];
                2'd2: merged[23:16] = d_q[7:0];
                default: merged[31:24] = d_q[7:0];
            endcase
        end
    end

    always_comb begin
        case (bus.addr[1:0])
            2'd0: ld_byte = bus.dm_rd[7:0];
            2'd1: ld_byte = bus.dm_rd[15:8];
            2'd2: ld_byte = bus.dm_rd[23:16];
            default: ld_byte = bus.dm_rd[31:24];
        endcase
        ld_half = bus.addr[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
        case (bus.funct3)
            F_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            F_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            F_BU: ld_data = {24'd0, ld_byte};
            F_HU: ld_data = {16'd0, ld_half};
            default: ld_data = bus.dm_rd;
        endcase
    end

    always_comb begin
        st_d         = st_q;
        a_d          = a_q;
        d_d          = d_q;
        f_d          = f_q;
        old_d        = old_q;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = bus.addr;
        bus.dm_wd    = bus.wdata;
        bus.rdata    = 32'd0;
        bus.stall    = 1'b0;
        bus.misalign = 1'b0;
        case (st_q)
            IDLE: begin
                bus.misalign = req & illegal;
                if (req && !illegal) begin
                    if (bus.mem_write) begin
                        if (bus.funct3 == F_W) begin
                            bus.dm_we = 1'b1;
                        end else begin
                            // Sub-word store: latch the old word, write it back merged next cycle.
                            bus.stall = 1'b1;
                            a_d       = bus.addr;
                            d_d       = bus.wdata;
                            f_d       = bus.funct3;
                            old_d     = bus.dm_rd;
                            st_d      = MERGE;
                        end
                    end else begin
                        bus.rdata = ld_data;
                    end
                end
            end
            MERGE: begin
                bus.dm_we   = 1'b1;
                bus.dm_addr = a_q;
                bus.dm_wd   = merged;
                st_d        = IDLE;
            end
            default: st_d = IDLE;
        endcase
        if (reset) begin
            bus.dm_we = 1'b0;
            bus.stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= IDLE;
            a_q   <= 32'd0;
            d_q   <= 32'd0;
            f_q   <= 3'd0;
            old_q <= 32'd0;
        end else begin
            st_q  <= st_d;
            a_q   <= a_d;
            d_q   <= d_d;
            f_q   <= f_d;
            old_q <= old_d;
        end
    end
endmodule
